ntlm_hash_seq: RTL and testbench
================================

Name: ntlm_hash_seq

Overview:
- Multi-cycle, parametrised NTLM hash engine: the clocked successor of the combinational NTLM calculator.
- Accepts an ASCII password of up to MAX_LEN characters and expands it to UTF-16LE.
- Builds the single MD4 padded block, runs the 48 MD4 steps over several cycles, and returns the 128-bit NTLM digest with a start/busy/done handshake.
- Sits in the cracker datapath between the candidate generator and the compare stage.

Parameters:
- MAX_LEN, 16, maximum password length in characters; legal range 1..27, so the password fits one MD4 block.
- STEPS_PER_CYCLE, 1, MD4 steps evaluated per clock; legal values 1, 2, 4 (must divide 16).
- LEN_W, derived localparam = $clog2(MAX_LEN+1), width of the length port.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- instr  input  [0:8*MAX_LEN-1]  password; instr[0:7] is the first character; bytes at index >= length are ignored
- length  input  [0:LEN_W-1]  character count, 0..MAX_LEN
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when hash/len_err are valid
- hash  output  [0:127]  digest in standard NTLM byte order; hash[0:7] is the low byte of A, hash[120:127] is the high byte of D
- len_err  output  1  length > MAX_LEN on the accepted request; valid with done

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Next state IDLE; busy=0, done=0, len_err=0, hash=0.
  - A, B, C, D and the block buffer are cleared.
  - Reset mid-operation aborts the operation: no done pulse, outputs as above.
- FSM states: IDLE -> LOAD -> ROUND -> FINAL -> IDLE.
- IDLE:
  - start=1 captures instr and length into registers; next state is LOAD.
  - busy rises the next cycle.
- LOAD (1 cycle):
  - Builds the 16 x 32-bit little-endian words M[0..15] from a 64-byte block.
  - Byte 2i = char i and byte 2i+1 = 0x00, for i < length.
  - Byte 2*length = 0x80; all other bytes 0.
  - M[14] = length*16 (bit count of the UTF-16 message); M[15] = 0.
  - A/B/C/D loaded with 67452301, efcdab89, 98badcfe, 10325476.
  - If length > MAX_LEN: len_err is set, ROUND is skipped, next state is FINAL with hash forced to 0.
- ROUND (48/STEPS_PER_CYCLE cycles):
  - Each cycle applies STEPS_PER_CYCLE consecutive MD4 steps.
  - Step counter k runs 0..47.
  - Steps 0-15: F = (b&c)|(~b&d), constant 0, shifts 3,7,11,19, word index k.
  - Steps 16-31: G = (b&c)|(b&d)|(c&d), constant 5A827999, shifts 3,5,9,13, word order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15.
  - Steps 32-47: H = b^c^d, constant 6ED9EBA1, shifts 3,9,11,15, word order 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15.
  - All additions are mod 2^32. Register rotation is a<-d, d<-c, c<-b, b<-rotl(sum).
- FINAL (1 cycle):
  - A += IV_A etc. (mod 2^32).
  - hash is registered from the byte-swapped A,B,C,D.
  - done pulses for 1 cycle while busy is still high; next state IDLE; busy=0 the following cycle.
- Latency: start accepted at edge N -> done high in cycle N+2+48/STEPS_PER_CYCLE (50 cycles for S=1, 14 for S=4).
- Holding: hash and len_err hold their values until the next accepted start (cleared at LOAD) or reset.
- start while busy=1 is ignored, with no queuing.
- start held high across the done cycle launches a new hash from IDLE on the next cycle, giving back-to-back throughput of 1 hash per 48/S+3 cycles.
- length=0 is legal: the empty-string hash.

Optional Feature:
- Macro NTLM_TARGET_MATCH_EN.
- When defined, two ports are added:
  - target input [0:127]: sampled with start.
  - match output 1: registered in FINAL as (hash == target) && !len_err, valid with done, held like hash, reset to 0.
- When undefined, neither port exists and there is no comparator logic.

Test Plan:
- Reset, then length=8, instr="password" -> done at cycle +50 (S=1), hash=8846f7eaee8fb117ad06bdd830b7586c, len_err=0.
- length=0 -> hash=31d6cfe0d16ae931b73c59d7e0c089c0; "123456" -> 32ed87bdb5fdc5e9cba88547376818d4; "Password" -> a4f49c406510bdcab6824ee7c30fd852.
- length=MAX_LEN+1 -> done after 2 cycles in FINAL, len_err=1, hash=0; a subsequent valid request clears len_err.
- Pulse start while busy, and assert rst at ROUND cycle 20 -> the mid-busy start is ignored; after reset, busy=0, done never pulses, hash=0, and the next request completes correctly.
- STEPS_PER_CYCLE=4 build with start held high across 3 passwords -> done every 15 cycles with the correct digests; every byte beyond length set to 0xFF has no effect on hash.
- NTLM_TARGET_MATCH_EN build, target=8846f7ea...586c: "password" -> match=1; "passwore" -> match=0.

Source files
------------

// File: rtl/ntlm_hash_seq.sv
// ============================================================================
// Module      : ntlm_hash_seq
// Description : Multi-cycle NTLM (MD4 over UTF-16LE) hash engine with start/busy/done.
//               Optional target comparator enabled by macro NTLM_TARGET_MATCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ntlm_hash_seq #(
    parameter int MAX_LEN         = 16,
    parameter int STEPS_PER_CYCLE = 1,
    localparam int LEN_W          = $clog2(MAX_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [0:8*MAX_LEN-1] instr,
    input  logic [0:LEN_W-1]     length,
    output logic                 busy,
    output logic                 done,
    output logic [0:127]         hash,
    output logic                 len_err
`ifdef NTLM_TARGET_MATCH_EN
    ,
    input  logic [0:127]         target,
    output logic                 match
`endif
);

    localparam logic [31:0] C_IV_A = 32'h67452301;
    localparam logic [31:0] C_IV_B = 32'hefcdab89;
    localparam logic [31:0] C_IV_C = 32'h98badcfe;
    localparam logic [31:0] C_IV_D = 32'h10325476;
    localparam logic [31:0] C_K2   = 32'h5a827999;
    localparam logic [31:0] C_K3   = 32'h6ed9eba1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ROUND = 2'd2,
        ST_FINAL = 2'd3
    } state_t;

    state_t               state_q;
    logic [0:8*MAX_LEN-1] instr_q;
    logic [LEN_W-1:0]     len_q;
    logic [31:0]          msg_q [16];
    logic [31:0]          a_q, b_q, c_q, d_q;
    logic [5:0]           k_q;
    logic                 busy_q, done_q, len_err_q;
    logic [0:127]         hash_q;

    function automatic logic [4:0] shamt(input logic [1:0] rnd, input logic [1:0] i);
        logic [4:0] s;
        s = 5'd3;
        case (rnd)
            2'd0:    case (i) 2'd0: s = 5'd3; 2'd1: s = 5'd7; 2'd2: s = 5'd11; default: s = 5'd19; endcase
            2'd1:    case (i) 2'd0: s = 5'd3; 2'd1: s = 5'd5; 2'd2: s = 5'd9;  default: s = 5'd13; endcase
            default: case (i) 2'd0: s = 5'd3; 2'd1: s = 5'd9; 2'd2: s = 5'd11; default: s = 5'd15; endcase
        endcase
        return s;
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    // Padded MD4 block: UTF-16LE characters, 0x80 terminator, bit length in M[14]
    logic [7:0]  blk [56];
    logic [31:0] msg_d [16];
    logic [5:0]  pad_idx;

    always_comb begin
        for (int j = 0; j < 56; j++) blk[j] = 8'h00;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len_q)) blk[2*i] = instr_q[8*i +: 8];
        end
        pad_idx = 6'({len_q, 1'b0});
        if (len_q <= LEN_W'(MAX_LEN)) blk[pad_idx] = 8'h80;
        for (int w = 0; w < 14; w++) begin
            msg_d[w] = {blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
        end
        msg_d[14] = 32'({len_q, 4'b0000});
        msg_d[15] = 32'h0;
    end

    // STEPS_PER_CYCLE chained MD4 steps starting at step k_q
    logic [31:0] a_d, b_d, c_d, d_d;

    always_comb begin
        logic [31:0] va, vb, vc, vd, fv, kc, sum;
        logic [5:0]  ks;
        logic [3:0]  widx;
        logic [4:0]  sh;
        va = a_q; vb = b_q; vc = c_q; vd = d_q;
        fv = '0; kc = '0; sum = '0; ks = '0; widx = '0; sh = '0;
        for (int s = 0; s < STEPS_PER_CYCLE; s++) begin
            ks = k_q + 6'(s);
            if (ks < 6'd16) begin
                fv   = (vb & vc) | (~vb & vd);
                kc   = 32'h0;
                widx = ks[3:0];
                sh   = shamt(2'd0, ks[1:0]);
            end else if (ks < 6'd32) begin
                fv   = (vb & vc) | (vb & vd) | (vc & vd);
                kc   = C_K2;
                widx = {ks[1:0], ks[3:2]};
                sh   = shamt(2'd1, ks[1:0]);
            end else begin
                fv   = vb ^ vc ^ vd;
                kc   = C_K3;
                widx = {ks[0], ks[1], ks[2], ks[3]};
                sh   = shamt(2'd2, ks[1:0]);
            end
            sum = va + fv + msg_q[widx] + kc;
            va  = vd;
            vd  = vc;
            vc  = vb;
            vb  = (sum << sh) | (sum >> (6'd32 - {1'b0, sh}));
        end
        a_d = va; b_d = vb; c_d = vc; d_d = vd;
    end

    logic [0:127] digest;
    assign digest = {bswap(a_q + C_IV_A), bswap(b_q + C_IV_B),
                     bswap(c_q + C_IV_C), bswap(d_q + C_IV_D)};

`ifdef NTLM_TARGET_MATCH_EN
    logic [0:127] target_q;
    logic         match_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            instr_q   <= '0;
            len_q     <= '0;
            for (int w = 0; w < 16; w++) msg_q[w] <= '0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
            hash_q    <= '0;
`ifdef NTLM_TARGET_MATCH_EN
            target_q  <= '0;
            match_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // IDLE is also the done cycle, so a held start chains hashes back to back
                ST_IDLE: begin
                    if (start) begin
                        instr_q <= instr;
                        len_q   <= length;
`ifdef NTLM_TARGET_MATCH_EN
                        target_q <= target;
`endif
                        busy_q  <= 1'b1;
                        state_q <= ST_LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    for (int w = 0; w < 16; w++) msg_q[w] <= msg_d[w];
                    a_q       <= C_IV_A;
                    b_q       <= C_IV_B;
                    c_q       <= C_IV_C;
                    d_q       <= C_IV_D;
                    k_q       <= '0;
                    hash_q    <= '0;
`ifdef NTLM_TARGET_MATCH_EN
                    match_q   <= 1'b0;
`endif
                    len_err_q <= (len_q > LEN_W'(MAX_LEN));
                    state_q   <= (len_q > LEN_W'(MAX_LEN)) ? ST_FINAL : ST_ROUND;
                end
                ST_ROUND: begin
                    a_q <= a_d;
                    b_q <= b_d;
                    c_q <= c_d;
                    d_q <= d_d;
                    k_q <= k_q + 6'(STEPS_PER_CYCLE);
                    if (k_q == 6'(48 - STEPS_PER_CYCLE)) state_q <= ST_FINAL;
                end
                default: begin
                    hash_q  <= len_err_q ? '0 : digest;
`ifdef NTLM_TARGET_MATCH_EN
                    match_q <= (digest == target_q) && !len_err_q;
`endif
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign hash    = hash_q;
    assign len_err = len_err_q;
`ifdef NTLM_TARGET_MATCH_EN
    assign match   = match_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ntlm_hash_seq.sv
// ============================================================================
// Module      : tb_ntlm_hash_seq
// Description : Directed bench for ntlm_hash_seq (S=1 and S=4 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ntlm_hash_seq;

    localparam logic [127:0] H_PASSWORD = 128'h8846f7eaee8fb117ad06bdd830b7586c;
    localparam logic [127:0] H_EMPTY    = 128'h31d6cfe0d16ae931b73c59d7e0c089c0;
    localparam logic [127:0] H_123456   = 128'h32ed87bdb5fdc5e9cba88547376818d4;
    localparam logic [127:0] H_PASSCAP  = 128'ha4f49c406510bdcab6824ee7c30fd852;

    logic         clk = 1'b0;
    logic         rst;
    logic         start, start4;
    logic [0:127] instr, instr4;
    logic [0:4]   length, length4;
    logic         busy, done, len_err, busy4, done4, len_err4;
    logic [0:127] hash, hash4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ntlm_hash_seq dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .length(length),
        .busy(busy), .done(done), .hash(hash), .len_err(len_err)
    );

    ntlm_hash_seq #(.STEPS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .instr(instr4), .length(length4),
        .busy(busy4), .done(done4), .hash(hash4), .len_err(len_err4)
    );

    typedef struct {
        string        pw;
        bit           ff;
        logic [127:0] exp;
    } vec_t;

    vec_t vt[6];

    function automatic logic [0:127] mk(input string s, input bit ff);
        logic [0:127] v;
        v = ff ? '1 : '0;
        for (int i = 0; i < s.len(); i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_hash(input string nm, input logic [0:127] pw, input logic [4:0] len,
                           input logic [127:0] eh, input logic ee, input int elat);
        int cyc;
        bit seen;
        @(negedge clk);
        instr  = pw;
        length = len;
        start  = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            seen = done;
        end
        chk({nm, " latency"}, 128'(cyc), 128'(elat));
        chk({nm, " hash"}, hash, eh);
        chk({nm, " len_err"}, 128'(len_err), 128'(ee));
        chk({nm, " busy at done"}, 128'(busy), 128'd1);
        @(posedge clk); #1;
        chk({nm, " busy after done"}, 128'(busy), 128'd0);
        chk({nm, " done width"}, 128'(done), 128'd0);
    endtask

    initial begin
        int cyc, ndone;
        bit seen;
        string pw4[3];
        logic [127:0] eh4[3];

        vt[0] = '{"password", 1'b0, H_PASSWORD};
        vt[1] = '{"",         1'b0, H_EMPTY};
        vt[2] = '{"123456",   1'b0, H_123456};
        vt[3] = '{"Password", 1'b0, H_PASSCAP};
        vt[4] = '{"password", 1'b1, H_PASSWORD};
        vt[5] = '{"123456",   1'b1, H_123456};

        rst = 1'b1; start = 1'b0; start4 = 1'b0;
        instr = '0; instr4 = '0; length = '0; length4 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 128'(busy), 128'd0);
        chk("reset done", 128'(done), 128'd0);
        chk("reset hash", hash, 128'd0);
        chk("reset len_err", 128'(len_err), 128'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_hash($sformatf("vec%0d", v), mk(vt[v].pw, vt[v].ff),
                    5'(vt[v].pw.len()), vt[v].exp, 1'b0, 50);
        end

        // Over-length request, then a valid one must clear len_err
        do_hash("len17", mk("abcdefghijklmnop", 1'b0), 5'd17, 128'd0, 1'b1, 2);
        do_hash("after len_err", mk("password", 1'b0), 5'd8, H_PASSWORD, 1'b0, 50);

        // Start pulsed while busy is ignored and not queued
        @(negedge clk);
        instr = mk("password", 1'b0); length = 5'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            seen  = done;
            start = (cyc == 10);
            if (cyc == 10) begin
                instr = mk("123456", 1'b0); length = 5'd6;
            end
        end
        chk("busy-start latency", 128'(cyc), 128'd50);
        chk("busy-start hash", hash, H_PASSWORD);
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("no queued hash", 128'(ndone), 128'd0);

        // Reset in the middle of ROUND aborts the operation
        @(negedge clk);
        instr = mk("123456", 1'b0); length = 5'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid reset busy", 128'(busy), 128'd0);
        chk("mid reset done", 128'(done), 128'd0);
        chk("mid reset hash", hash, 128'd0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("aborted op silent", 128'(ndone), 128'd0);
        do_hash("after reset", mk("Password", 1'b0), 5'd8, H_PASSCAP, 1'b0, 50);

        // S=4 instance, start held across three requests, 0xFF beyond length
        pw4[0] = "Password"; eh4[0] = H_PASSCAP;
        pw4[1] = "";         eh4[1] = H_EMPTY;
        pw4[2] = "password"; eh4[2] = H_PASSWORD;
        @(negedge clk);
        instr4 = mk(pw4[0], 1'b1); length4 = 5'(pw4[0].len()); start4 = 1'b1;
        @(posedge clk); #1;
        instr4 = mk(pw4[1], 1'b1); length4 = 5'(pw4[1].len());
        cyc = 0;
        for (int p = 0; p < 3; p++) begin
            seen = 1'b0;
            while (!seen && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
                seen = done4;
            end
            chk($sformatf("s4 pw%0d interval", p), 128'(cyc), (p == 0) ? 128'd14 : 128'd15);
            chk($sformatf("s4 pw%0d hash", p), hash4, eh4[p]);
            chk($sformatf("s4 pw%0d len_err", p), 128'(len_err4), 128'd0);
            if (p < 2) begin
                @(posedge clk); #1;
                cyc = 1;
                if (p == 0) begin
                    instr4 = mk(pw4[2], 1'b1); length4 = 5'(pw4[2].len());
                end else begin
                    start4 = 1'b0;
                end
            end
        end
        @(posedge clk); #1;
        chk("s4 busy after last", 128'(busy4), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
